ex_mul_sequencer: RTL and testbench
===================================

// Module: ex_mul_sequencer
// PURPOSE
//  Sequences the EX-stage multiply (ALU control code 5, MUL) as an iterative
//  shift-add operation instead of a single-cycle array multiplier.
//  - Sits beside the ALU in EX.
//  - Asserts a stall to the hazard/pipeline-freeze logic while the multiply runs.
//  - Hands the product to the EX/MEM mux once the multiply finishes.
//  - Cooperates with the cache stall and the branch flush.
// PARAMETERS
//  XLEN        32   operand/result width
//  CNT_W       6    iteration counter width; must satisfy 2^CNT_W > XLEN
// PORTS
//  clk_i         in   1     clock; all state updates on the rising edge
//  rst_i         in   1     reset, synchronous, active-high
//  valid_i       in   1     EX stage holds a live (non-bubble) instruction
//  ALUCtrl_i     in   4     ALU control code of the EX instruction
//  rs1_data_i    in   XLEN  forwarded operand A (multiplicand)
//  rs2_data_i    in   XLEN  forwarded operand B (multiplier)
//  mem_stall_i   in   1     cache miss stall; pipeline frozen while high
//  flush_i       in   1     kill EX instruction (branch taken / redirect)
//  stall_o       out  1     freeze PC, IF/ID, ID/EX; insert bubble into EX/MEM
//  busy_o        out  1     state == BUSY
//  done_o        out  1     result_o valid for the EX instruction
//  result_o      out  XLEN  low XLEN bits of rs1*rs2
// BEHAVIOUR
//  Reset (sync, highest priority):
//   - state=IDLE; acc, mcand, mplier, cnt, result_o = 0.
//   - stall_o, busy_o, done_o = 0.
//  Start condition: start = valid_i & (ALUCtrl_i==ALU_MUL) & ~flush_i, in IDLE only.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   - IDLE
//     - on start: latch mcand=rs1_data_i, mplier=rs2_data_i, acc=0, cnt=0;
//       next state BUSY.
//     - stall_o asserted combinationally in the start cycle.
//   - BUSY, one step per cycle:
//     - if mplier[0]: acc += mcand (mod 2^XLEN).
//     - mcand <<= 1; mplier >>= 1; cnt++.
//     - stall_o=1.
//     - go to DONE when cnt==XLEN-1, or early when the updated mplier==0.
//     - on leaving BUSY: result_o <= updated acc.
//   - DONE
//     - done_o=1; stall_o=0 so the pipeline advances the MUL.
//     - stay in DONE while mem_stall_i=1, holding result_o and done_o.
//     - go to IDLE on the first cycle with mem_stall_i=0.
//     - DONE never re-starts, so the same MUL is never issued twice.
//  Latency:
//   - start cycle plus k BUSY cycles, k = min(XLEN, index of the highest set
//     bit of rs2 + 1); done at cycle k+1.
//   - rs2==0: exactly one BUSY cycle.
//   - Worst case (rs2[XLEN-1]=1): 1 + XLEN stall cycles.
//  mem_stall_i during BUSY: iteration continues (operands already latched).
//  flush_i:
//   - in any state, next state IDLE; no done_o pulse.
//   - stall_o=0 in the flush cycle.
//   - result_o is not updated.
//   - Priority: rst_i > flush_i > FSM.
//  Arithmetic:
//   - unsigned shift-add, truncated to XLEN.
//   - The low half is identical for signed operands, so no sign handling.
//  Non-MUL ALUCtrl_i: block idle; stall_o=0, done_o=0.
//  Back-to-back MULs: the second starts in the cycle after DONE exits.
//  Outputs: result_o registered; stall_o, busy_o, done_o decoded from state
//  (plus start).
// STRUCTURE
//  - Shared package ex_ctrl_pkg:
//    - ALU control codes (ALU_AND=0 .. ALU_MUL=5 .. ALU_BEQ=9).
//    - FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
//  - One sub-module: shift_add_mul_dp. It holds acc/mcand/mplier/cnt and takes
//    load/step controls; it outputs acc_next, mplier_next_zero and last_step.
//  - The top level holds the FSM, stall/done decode and the result_o register.
// TESTING
//  1. 7*6, no stalls -> stall_o high 4 cycles (start + 3 BUSY); done_o 1 cycle;
//     result_o=42.
//  2. 0xFFFFFFFF*0xFFFFFFFF -> 33 stall cycles; result_o=0x00000001.
//  3. 5*0 -> one BUSY cycle, result_o=0; and -3*4 (0xFFFFFFFD*4) -> 0xFFFFFFF4.
//  4. mem_stall_i high 5 cycles overlapping the BUSY->DONE transition ->
//     done_o held, result_o stable, single IDLE return; no second start.
//  5. flush_i on the 3rd BUSY cycle -> IDLE next cycle; no done_o;
//     result_o unchanged.
//  6. rst_i mid-BUSY -> all outputs 0 next cycle; then two back-to-back MULs
//     (3*3, 2*8) -> result_o 9 then 16, each with its own done_o pulse.

Source files
------------

// File: rtl/ex_ctrl_pkg.sv
// Shared EX-stage control definitions: ALU control codes and the multiply
// sequencer state encoding.
package ex_ctrl_pkg;

    localparam int ALU_CTRL_W = 4;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd3,
        ALU_SLT = 4'd4,
        ALU_MUL = 4'd5,
        ALU_XOR = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_BEQ = 4'd9
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    function automatic logic is_mul(input logic [ALU_CTRL_W-1:0] ctrl);
        return ctrl == ALU_MUL;
    endfunction

endpackage

// File: rtl/shift_add_mul_dp.sv
// Shift-add multiply datapath: one multiplier bit is consumed per step,
// producing the low XLEN bits of the product in acc.
module shift_add_mul_dp #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] mcand_i,
    input  logic [XLEN-1:0] mplier_i,
    output logic [XLEN-1:0] acc_next_o,
    output logic            mplier_next_zero_o,
    output logic            last_step_o
);

    logic [XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0]  acc_step;
    logic [XLEN-1:0]  mplier_step;

    // Values this step would produce; the controller uses them to leave BUSY
    // in the same cycle the final add happens.
    always_comb begin
        acc_step    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_step = mplier_q >> 1;
    end

    assign acc_next_o         = acc_step;
    assign mplier_next_zero_o = (mplier_step == '0);
    assign last_step_o        = (cnt_q == CNT_W'(XLEN - 1));

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            cnt_d    = '0;
        end else if (step_i) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_step;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ex_mul_sequencer.sv
// EX-stage iterative multiply sequencer: stalls the pipeline while the
// shift-add datapath runs, then presents the product for one advancing cycle.
module ex_mul_sequencer
    import ex_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [ALU_CTRL_W-1:0] ALUCtrl_i,
    input  logic [XLEN-1:0]       rs1_data_i,
    input  logic [XLEN-1:0]       rs2_data_i,
    input  logic                  mem_stall_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [XLEN-1:0]       result_o
);

    mul_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            start;
    logic            dp_step;
    logic [XLEN-1:0] acc_next;
    logic            mplier_next_zero;
    logic            last_step;

    assign start   = valid_i & is_mul(ALUCtrl_i) & ~flush_i & (state_q == ST_IDLE);
    assign dp_step = (state_q == ST_BUSY) & ~flush_i;

    shift_add_mul_dp #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_dp (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .load_i             (start),
        .step_i             (dp_step),
        .mcand_i            (rs1_data_i),
        .mplier_i           (rs2_data_i),
        .acc_next_o         (acc_next),
        .mplier_next_zero_o (mplier_next_zero),
        .last_step_o        (last_step)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) state_d = ST_BUSY;
                end
                ST_BUSY: begin
                    if (last_step || mplier_next_zero) begin
                        state_d  = ST_DONE;
                        result_d = acc_next;
                    end
                end
                ST_DONE: begin
                    // Held while the cache freezes the pipe so the MUL is not lost.
                    if (!mem_stall_i) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    assign stall_o  = start | ((state_q == ST_BUSY) & ~flush_i);
    assign busy_o   = (state_q == ST_BUSY);
    assign done_o   = (state_q == ST_DONE) & ~flush_i;
    assign result_o = result_q;

endmodule

// File: tb/tb_ex_mul_sequencer.sv
// Self-checking bench for ex_mul_sequencer: directed scenarios plus random
// multiplies compared against an arithmetic reference of latency and product.
module tb_ex_mul_sequencer;
    import ex_ctrl_pkg::*;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            valid_i;
    logic [3:0]      ALUCtrl_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            mem_stall_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    int              n_assert = 0;
    int              n_fail   = 0;
    logic [XLEN-1:0] last_result;

    always #5 clk_i = ~clk_i;

    ex_mul_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ALUCtrl_i   (ALUCtrl_i),
        .rs1_data_i  (rs1_data_i),
        .rs2_data_i  (rs2_data_i),
        .mem_stall_i (mem_stall_i),
        .flush_i     (flush_i),
        .stall_o     (stall_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o)
    );

    // Number of BUSY cycles: position of the highest set multiplier bit, minimum one.
    function automatic int ref_latency(input logic [XLEN-1:0] b);
        int k = 1;
        for (int i = 0; i < XLEN; i++)
            if (b[i]) k = i + 1;
        return k;
    endfunction

    function automatic logic [XLEN-1:0] ref_product(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        return p[XLEN-1:0];
    endfunction

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_outputs(input string tag, input logic st, input logic bz, input logic dn,
                               input logic [XLEN-1:0] res);
        chk({tag, " stall"}, 32'(stall_o), 32'(st));
        chk({tag, " busy"}, 32'(busy_o), 32'(bz));
        chk({tag, " done"}, 32'(done_o), 32'(dn));
        chk({tag, " result"}, result_o, res);
    endtask

    // One MUL issued at the current cycle; mem_stall_i is high on cycles
    // [ms_start, ms_start+ms_len) counted from the issue cycle. With tail set,
    // one trailing idle cycle is checked; otherwise the next MUL may follow at once.
    task automatic run_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input int ms_start, input int ms_len, input bit tail);
        int              k;
        int              done_end;
        logic [XLEN-1:0] exp_p;
        logic [XLEN-1:0] prev;
        k        = ref_latency(b);
        exp_p    = ref_product(a, b);
        prev     = last_result;
        done_end = k + 1;
        while (done_end >= ms_start && done_end < ms_start + ms_len) done_end++;
        for (int c = 0; c <= done_end; c++) begin
            valid_i     = 1'b1;
            ALUCtrl_i   = ALU_MUL;
            rs1_data_i  = a;
            rs2_data_i  = b;
            flush_i     = 1'b0;
            mem_stall_i = (c >= ms_start) && (c < ms_start + ms_len);
            @(negedge clk_i);
            chk_outputs($sformatf("mul %h*%h c%0d", a, b, c),
                        c <= k, (c >= 1) && (c <= k), c >= k + 1,
                        (c >= k + 1) ? exp_p : prev);
            next_cycle();
        end
        last_result = exp_p;
        $display("mul %h * %h -> expected %h after %0d busy cycles (done held %0d cycles), dut %h",
                 a, b, exp_p, k, done_end - k, result_o);
        if (tail) begin
            valid_i     = 1'b0;
            mem_stall_i = 1'b0;
            @(negedge clk_i);
            chk_outputs($sformatf("mul %h*%h idle", a, b), 1'b0, 1'b0, 1'b0, exp_p);
            next_cycle();
        end
    endtask

    initial begin
        logic [XLEN-1:0] ra;
        logic [XLEN-1:0] rb;
        int              ms_s;
        int              ms_l;

        rst_i       = 1'b1;
        valid_i     = 1'b0;
        ALUCtrl_i   = ALU_ADD;
        rs1_data_i  = '0;
        rs2_data_i  = '0;
        mem_stall_i = 1'b0;
        flush_i     = 1'b0;
        last_result = '0;
        next_cycle();
        @(negedge clk_i);
        chk_outputs("reset", 1'b0, 1'b0, 1'b0, '0);
        $display("reset applied");
        next_cycle();
        rst_i = 1'b0;

        // Non-MUL instructions never engage the sequencer.
        for (int i = 0; i < 8; i++) begin
            valid_i    = 1'($urandom_range(0, 1));
            ALUCtrl_i  = 4'($urandom_range(0, 15));
            if (ALUCtrl_i == ALU_MUL) ALUCtrl_i = ALU_XOR;
            rs1_data_i = $urandom;
            rs2_data_i = $urandom;
            @(negedge clk_i);
            chk_outputs($sformatf("nonmul ctrl%0d", ALUCtrl_i), 1'b0, 1'b0, 1'b0, '0);
            $display("non-mul ctrl %0d valid %0d", ALUCtrl_i, valid_i);
            next_cycle();
        end
        valid_i = 1'b0;

        run_mul(32'd7, 32'd6, 99, 0, 1'b1);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 99, 0, 1'b1);
        run_mul(32'd5, 32'd0, 99, 0, 1'b1);
        run_mul(32'hFFFF_FFFD, 32'd4, 99, 0, 1'b1);
        run_mul(32'd7, 32'd6, 2, 5, 1'b1);

        // MUL under flush in IDLE must not start.
        valid_i    = 1'b1;
        ALUCtrl_i  = ALU_MUL;
        rs1_data_i = 32'd11;
        rs2_data_i = 32'd13;
        flush_i    = 1'b1;
        @(negedge clk_i);
        chk_outputs("flush idle", 1'b0, 1'b0, 1'b0, last_result);
        next_cycle();
        valid_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk_i);
        chk_outputs("flush idle next", 1'b0, 1'b0, 1'b0, last_result);
        $display("flushed MUL in idle ignored");
        next_cycle();

        // Flush on the third BUSY cycle.
        valid_i    = 1'b1;
        ALUCtrl_i  = ALU_MUL;
        rs1_data_i = 32'h1234_5678;
        rs2_data_i = 32'h0000_FFFF;
        for (int c = 0; c < 4; c++) begin
            flush_i = (c == 3);
            @(negedge clk_i);
            chk_outputs($sformatf("flush busy c%0d", c), c < 3, c >= 1, 1'b0, last_result);
            next_cycle();
        end
        valid_i = 1'b0;
        flush_i = 1'b0;
        for (int c = 4; c < 8; c++) begin
            @(negedge clk_i);
            chk_outputs($sformatf("flush busy c%0d", c), 1'b0, 1'b0, 1'b0, last_result);
            next_cycle();
        end
        $display("flush on third busy cycle, result held %h", result_o);

        // Reset in the middle of BUSY.
        valid_i    = 1'b1;
        ALUCtrl_i  = ALU_MUL;
        rs1_data_i = 32'h0000_F00F;
        rs2_data_i = 32'h8000_0001;
        next_cycle();
        next_cycle();
        valid_i = 1'b0;
        rst_i   = 1'b1;
        next_cycle();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk_outputs("reset mid busy", 1'b0, 1'b0, 1'b0, '0);
        $display("reset mid busy, result %h", result_o);
        last_result = '0;
        next_cycle();

        run_mul(32'd3, 32'd3, 99, 0, 1'b0);
        run_mul(32'd2, 32'd8, 99, 0, 1'b1);

        for (int i = 0; i < 16; i++) begin
            ra   = $urandom;
            rb   = $urandom >> $urandom_range(0, 31);
            ms_s = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, 12)) : 99;
            ms_l = int'($urandom_range(1, 6));
            run_mul(ra, rb, ms_s, ms_l, (i == 15) || ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
